// File: rtl/frogger_pkg.sv
// Shared colour constants, lane config layout and screen defaults for the
// Frogger VGA pixel pipeline.
package frogger_pkg;

    localparam logic [7:0] COLOR_BLACK  = 8'b000_000_00;
    localparam logic [7:0] COLOR_GREEN  = 8'b000_111_00;
    localparam logic [7:0] COLOR_BLUE   = 8'b000_000_11;
    localparam logic [7:0] COLOR_RED    = 8'b111_000_00;
    localparam logic [7:0] COLOR_YELLOW = 8'b111_111_00;

    localparam int SPEED_W  = 4;
    localparam int LEN_W    = 8;
    localparam int COLOR_W  = 8;
    localparam int OFFSET_W = 8;
    localparam int COORD_W  = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef struct packed {
        logic [SPEED_W-1:0] speed;
        logic               dir;
        logic [LEN_W-1:0]   len;
        logic [COLOR_W-1:0] obj_color;
        logic [COLOR_W-1:0] bg_color;
        logic               hazard;
    } lane_cfg_t;

endpackage

// File: rtl/frogger_lane_renderer_lane_scroller.sv
// One lane: config registers plus the per-frame scroll offset.
module lane_scroller
    import frogger_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                we,
    input  lane_cfg_t           cfg,
    output lane_cfg_t           lane_cfg,
    output logic [OFFSET_W-1:0] offset
);

    // Offset update reads the registered speed/dir, so a same-cycle write
    // only affects the following frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_cfg <= '0;
            offset   <= '0;
        end else begin
            if (frame_start) begin
                if (lane_cfg.dir)
                    offset <= offset + {4'b0, lane_cfg.speed};
                else
                    offset <= offset - {4'b0, lane_cfg.speed};
            end
            if (we)
                lane_cfg <= cfg;
        end
    end

endmodule

// File: rtl/frogger_lane_renderer.sv
// Lane-based pixel colour source with frog sprite overlay and per-frame
// frog/hazard collision detection; output is one cycle behind next_x/next_y.
module frogger_lane_renderer
    import frogger_pkg::*;
#(
    parameter int         NUM_LANES    = 8,
    parameter int         LANE_HEIGHT  = 60,
    parameter int         H_ACTIVE     = H_ACTIVE_DEF,
    parameter int         V_ACTIVE     = V_ACTIVE_DEF,
    parameter int         FROG_SIZE    = 16,
    parameter logic [7:0] FROG_COLOR   = COLOR_YELLOW,
    parameter logic [7:0] BORDER_COLOR = COLOR_BLUE,
    parameter int         LANE_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
)(
    input  logic               clock,
    input  logic               reset,
    input  logic [COORD_W-1:0] next_x,
    input  logic [COORD_W-1:0] next_y,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] frog_x,
    input  logic [COORD_W-1:0] frog_y,
    input  logic               cfg_we,
    input  logic [LANE_W-1:0]  cfg_lane,
    input  logic [SPEED_W-1:0] cfg_speed,
    input  logic               cfg_dir,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [COLOR_W-1:0] cfg_obj_color,
    input  logic [COLOR_W-1:0] cfg_bg_color,
    input  logic               cfg_hazard,
    output logic [COLOR_W-1:0] color_out,
    output logic               hit
);

    lane_cfg_t                               cfg_in;
    lane_cfg_t [NUM_LANES-1:0]               lane_cfg;
    logic      [NUM_LANES-1:0][OFFSET_W-1:0] lane_off;

    assign cfg_in = '{speed: cfg_speed, dir: cfg_dir, len: cfg_len,
                      obj_color: cfg_obj_color, bg_color: cfg_bg_color,
                      hazard: cfg_hazard};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_scroller u_lane (
            .clock       (clock),
            .reset       (reset),
            .frame_start (frame_start),
            .we          (cfg_we && (cfg_lane == LANE_W'(g))),
            .cfg         (cfg_in),
            .lane_cfg    (lane_cfg[g]),
            .offset      (lane_off[g])
        );
    end

    // Lane index by threshold chain; rows past the last lane never use it.
    logic [LANE_W-1:0] lane_idx;
    always_comb begin
        lane_idx = '0;
        for (int k = 1; k < NUM_LANES; k++)
            if (int'(next_y) >= k * LANE_HEIGHT)
                lane_idx = LANE_W'(k);
    end

    lane_cfg_t           sel_cfg;
    logic [OFFSET_W-1:0] sel_off;
    logic [7:0]          pat_pos;
    logic                obj_pix;

    assign sel_cfg = lane_cfg[lane_idx];
    assign sel_off = lane_off[lane_idx];
    assign pat_pos = next_x[7:0] + sel_off;
    assign obj_pix = pat_pos < sel_cfg.len;

    logic [COORD_W:0] x_ext, y_ext, fx_ext, fy_ext;
    logic             visible, in_lanes, frog_pix, cur_hit;

    assign x_ext    = {1'b0, next_x};
    assign y_ext    = {1'b0, next_y};
    assign fx_ext   = {1'b0, frog_x};
    assign fy_ext   = {1'b0, frog_y};
    assign visible  = (int'(next_x) < H_ACTIVE) && (int'(next_y) < V_ACTIVE);
    assign in_lanes = int'(next_y) < NUM_LANES * LANE_HEIGHT;
    assign frog_pix = (x_ext >= fx_ext) && (x_ext < fx_ext + 11'(FROG_SIZE)) &&
                      (y_ext >= fy_ext) && (y_ext < fy_ext + 11'(FROG_SIZE));
    assign cur_hit  = visible && frog_pix && in_lanes && obj_pix && sel_cfg.hazard;

    logic [COLOR_W-1:0] pix_color;
    always_comb begin
        pix_color = sel_cfg.bg_color;
        if (!visible)
            pix_color = COLOR_BLACK;
        else if (frog_pix)
            pix_color = FROG_COLOR;
        else if (!in_lanes)
            pix_color = BORDER_COLOR;
        else if (obj_pix)
            pix_color = sel_cfg.obj_color;
    end

    // armed suppresses the partial frame between reset release and the first
    // frame_start, so hit first reflects a complete frame.
    logic hit_acc, armed;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_out <= '0;
            hit       <= 1'b0;
            hit_acc   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            color_out <= pix_color;
            if (frame_start) begin
                hit     <= armed & (hit_acc | cur_hit);
                hit_acc <= 1'b0;
                armed   <= 1'b1;
            end else if (cur_hit) begin
                hit_acc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frogger_lane_renderer.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares.
module tb_frogger_lane_renderer;
    localparam int NL = 7;
    localparam int LH = 60;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] next_x, next_y, frog_x, frog_y;
    logic       frame_start, cfg_we, cfg_dir, cfg_hazard;
    logic [2:0] cfg_lane;
    logic [3:0] cfg_speed;
    logic [7:0] cfg_len, cfg_obj_color, cfg_bg_color;
    logic [7:0] color_out;
    logic       hit;

    frogger_lane_renderer #(.NUM_LANES(NL), .LANE_HEIGHT(LH)) dut (
        .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
        .frame_start(frame_start), .frog_x(frog_x), .frog_y(frog_y),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_speed(cfg_speed),
        .cfg_dir(cfg_dir), .cfg_len(cfg_len), .cfg_obj_color(cfg_obj_color),
        .cfg_bg_color(cfg_bg_color), .cfg_hazard(cfg_hazard),
        .color_out(color_out), .hit(hit)
    );

    always #20 clock = ~clock;

    typedef struct {
        logic [7:0] c;
        logic       h;
        int         x;
        int         y;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: lane state as plain integers.
    int m_speed[NL], m_dir[NL], m_len[NL], m_obj[NL], m_bg[NL], m_haz[NL], m_off[NL];
    int m_hit, m_acc, m_fs;

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_speed[i] = 0; m_dir[i] = 0; m_len[i] = 0; m_obj[i] = 0;
            m_bg[i] = 0; m_haz[i] = 0; m_off[i] = 0;
        end
        m_hit = 0; m_acc = 0; m_fs = 0;
    endfunction

    task automatic tick();
        int x, y, fx, fy, lane, p, col, cur;
        bit vis, frog;
        exp_t e;
        x = int'(next_x); y = int'(next_y); fx = int'(frog_x); fy = int'(frog_y);
        vis  = (x < 640) && (y < 480);
        frog = (x >= fx) && (x < fx + 16) && (y >= fy) && (y < fy + 16);
        cur  = 0;
        if (!vis) col = 0;
        else if (frog) col = 8'hFC;
        else if (y >= NL * LH) col = 8'h03;
        else col = -1;
        if (vis && y < NL * LH) begin
            lane = y / LH;
            p = ((x % 256) + m_off[lane]) % 256;
            if (col < 0) col = (p < m_len[lane]) ? m_obj[lane] : m_bg[lane];
            if (frog && p < m_len[lane] && m_haz[lane] != 0) cur = 1;
        end
        if (frame_start) begin
            m_hit = (m_fs > 0) ? (m_acc | cur) : 0;
            m_acc = 0;
            m_fs++;
            for (int i = 0; i < NL; i++)
                m_off[i] = (m_dir[i] != 0) ? (m_off[i] + m_speed[i]) % 256
                                           : (m_off[i] + 256 - m_speed[i]) % 256;
        end else if (cur != 0) begin
            m_acc = 1;
        end
        if (cfg_we && int'(cfg_lane) < NL) begin
            m_speed[cfg_lane] = int'(cfg_speed); m_dir[cfg_lane] = int'(cfg_dir);
            m_len[cfg_lane] = int'(cfg_len); m_obj[cfg_lane] = int'(cfg_obj_color);
            m_bg[cfg_lane] = int'(cfg_bg_color); m_haz[cfg_lane] = int'(cfg_hazard);
        end
        e.c = 8'(col); e.h = 1'(m_hit); e.x = x; e.y = y;
        q.push_back(e);
        @(negedge clock);
        frame_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        next_x = 10'(x); next_y = 10'(y);
        tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
    endtask

    task automatic write_lane(input int lane, input int spd, input int dir, input int len,
                              input int obj, input int bg, input int haz);
        cfg_we = 1'b1; cfg_lane = 3'(lane); cfg_speed = 4'(spd); cfg_dir = 1'(dir);
        cfg_len = 8'(len); cfg_obj_color = 8'(obj); cfg_bg_color = 8'(bg);
        cfg_hazard = 1'(haz);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (color_out !== 8'h00) begin
            errors++; $display("FAIL reset_color: got %02h want 00", color_out);
        end
        checks++;
        if (hit !== 1'b0) begin
            errors++; $display("FAIL reset_hit: got %b want 0", hit);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: output is always valid one edge after each driven pixel.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (color_out !== e.c) begin
                    errors++;
                    $display("FAIL color(x=%0d,y=%0d): got %02h want %02h", e.x, e.y, color_out, e.c);
                end
                checks++;
                if (hit !== e.h) begin
                    errors++;
                    $display("FAIL hit(x=%0d,y=%0d): got %b want %b", e.x, e.y, hit, e.h);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; next_x = '0; next_y = '0; frame_start = 1'b0;
        frog_x = 10'd700; frog_y = 10'd500; cfg_we = 1'b0; cfg_lane = '0;
        cfg_speed = '0; cfg_dir = 1'b0; cfg_len = '0; cfg_obj_color = '0;
        cfg_bg_color = '0; cfg_hazard = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        do_reset();

        // Static lane, border rows, off-screen pixels.
        write_lane(0, 0, 0, 0, 8'hE0, 8'h1C, 0);
        for (int i = 0; i < 12; i++) pix($urandom_range(0, 639), $urandom_range(0, 59));
        for (int i = 0; i < 6; i++) pix($urandom_range(0, 639), $urandom_range(NL * LH, 479));
        pix(640, 10); pix(10, 480); pix(1023, 1023);
        write_lane(7, 3, 1, 50, 8'hFF, 8'hFF, 1);   // out-of-range lane: ignored
        pix(20, 30);

        // Scroll with wrap: 52 frames of -5 leaves offset 252.
        write_lane(1, 5, 0, 10, 8'hE0, 8'h03, 0);
        for (int i = 0; i < 52; i++) frame();
        pix(4, 70); pix(3, 70); pix(13, 70); pix(14, 70); pix(260, 100);

        // Same-cycle config write and frame_start.
        do_reset();
        write_lane(1, 3, 0, 1, 8'hE0, 8'h1C, 0);
        cfg_we = 1'b1; cfg_lane = 3'd1; cfg_speed = 4'd7; frame();
        pix(3, 70); pix(2, 70);
        frame();
        pix(10, 70); pix(3, 70);

        // Collision: object covers x 0..127 in lane 1, frog at (100,70).
        do_reset();
        frame();
        write_lane(1, 0, 0, 128, 8'hE0, 8'h1C, 1);
        frog_x = 10'd100; frog_y = 10'd70;
        pix(105, 75); pix(99, 75); frame();
        pix(200, 75); frame();
        write_lane(1, 0, 0, 128, 8'hE0, 8'h1C, 0);
        pix(105, 75); frame();
        pix(50, 70);
        frog_x = 10'd630;
        pix(635, 75); pix(639, 75); pix(640, 75); pix(645, 75);

        // Reset mid-frame with hit set; first frame after release stays clear.
        frog_x = 10'd100;
        write_lane(1, 0, 0, 128, 8'hE0, 8'h1C, 1);
        pix(110, 80); frame(); pix(110, 80);
        do_reset();
        write_lane(1, 0, 0, 128, 8'hE0, 8'h1C, 1);
        pix(110, 80); frame();
        pix(110, 80); frame();
        pix(20, 20);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                frog_x = 10'($urandom_range(0, 660));
                frog_y = 10'($urandom_range(0, 500));
            end
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1; cfg_lane = 3'($urandom_range(0, 7));
                cfg_speed = 4'($urandom); cfg_dir = 1'($urandom);
                cfg_len = 8'($urandom); cfg_obj_color = 8'($urandom);
                cfg_bg_color = 8'($urandom); cfg_hazard = 1'($urandom);
            end
            frame_start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 0) begin
                next_x = 10'(int'(frog_x) + $urandom_range(0, 19) - 2);
                next_y = 10'(int'(frog_y) + $urandom_range(0, 19) - 2);
            end else begin
                next_x = 10'($urandom_range(0, 799));
                next_y = 10'($urandom_range(0, 524));
            end
            tick();
        end

        repeat (2) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
